// File: rtl/dmem_access_ctrl_pkg.sv
// Shared MEM-stage definitions: sequencer states, word-alignment mask, default ack timeout.
// No logic of its own; latency and backpressure are defined by the modules that import it.
package dmem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [31:0] ALIGN_MASK      = 32'h0000_0003;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr & ALIGN_MASK) == 32'h0000_0000;
    endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Ack-wait counter: counts enabled cycles, saturates at LIMIT and flags it combinationally.
// One-cycle update latency; clear has priority over enable; no backpressure.
module dmem_timeout_cnt #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WIDTH-1:0] count;

    assign expired = (count == WIDTH'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: runs the data-memory req/ack handshake and freezes the front of the pipe.
// Adds 0 cycles for non-memory ops, 2 + ack-wait cycles for aligned accesses; stall is the backpressure.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_MemRead,
    input  logic        mem_MemWrite,
    input  logic        wb_RegWrite,
    input  logic [31:0] AluResult,
    input  logic [31:0] MuxForwardB,
    output logic        stall,
    output logic        wb_RegWrite_gated,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err_align,
    output logic        err_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t state;
    logic   access;
    logic   aligned;
    logic   launch;
    logic   fault;
    logic   cnt_clear;
    logic   cnt_enable;
    logic   cnt_expired;

    assign access  = mem_MemRead | mem_MemWrite;
    assign aligned = is_aligned(AluResult);
    assign launch  = (state == ST_IDLE) && access && aligned;

    // The counter already reads 1 in the first ACCESS cycle, so it equals
    // TIMEOUT exactly in the TIMEOUT-th cycle spent waiting for the ack.
    assign cnt_enable = launch || (state == ST_ACCESS);
    assign cnt_clear  = (state == ST_DONE);

    dmem_timeout_cnt #(
        .WIDTH (CNT_W),
        .LIMIT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    assign err_align   = (state == ST_IDLE) && access && !aligned;
    assign err_timeout = (state == ST_ACCESS) && cnt_expired && !mem_ack;

    always_comb begin
        stall             = 1'b0;
        wb_RegWrite_gated = 1'b0;
        case (state)
            ST_IDLE: begin
                stall             = access && aligned;
                wb_RegWrite_gated = wb_RegWrite && !access;
            end
            ST_ACCESS: begin
                stall = 1'b1;
            end
            ST_DONE: begin
                wb_RegWrite_gated = wb_RegWrite && !fault;
            end
            default: begin
                stall             = 1'b0;
                wb_RegWrite_gated = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            load_data <= 32'h0000_0000;
            fault     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        mem_addr  <= AluResult & ~ALIGN_MASK;
                        mem_wdata <= MuxForwardB;
                        mem_we    <= mem_MemWrite;
                        mem_req   <= 1'b1;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // An ack landing in the expiry cycle still completes the access.
                    if (mem_ack) begin
                        load_data <= mem_rdata;
                        mem_req   <= 1'b0;
                        state     <= ST_DONE;
                    end else if (cnt_expired) begin
                        fault   <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    fault <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    fault   <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl with a 4-cycle ack timeout: vector table plus a reset-mid-access sequence.
module tb_dmem_access_ctrl;

    localparam int unsigned TMO        = 4;
    localparam logic [31:0] STRAY_DATA = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_MemRead = 1'b0;
    logic        mem_MemWrite = 1'b0;
    logic        wb_RegWrite = 1'b0;
    logic [31:0] AluResult = 32'h0;
    logic [31:0] MuxForwardB = 32'h0;
    logic        stall;
    logic        wb_RegWrite_gated;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        err_align;
    logic        err_timeout;

    dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_MemRead       (mem_MemRead),
        .mem_MemWrite      (mem_MemWrite),
        .wb_RegWrite       (wb_RegWrite),
        .AluResult         (AluResult),
        .MuxForwardB       (MuxForwardB),
        .stall             (stall),
        .wb_RegWrite_gated (wb_RegWrite_gated),
        .load_data         (load_data),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata),
        .err_align         (err_align),
        .err_timeout       (err_timeout)
    );

    always #5 clk = ~clk;

    // ack_at: ACCESS cycle (1-based) in which the memory acks, 0 = never.
    // stalls: cycles with stall high; the instruction retires in cycle stalls+1.
    typedef struct {
        logic        rd;
        logic        wr;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_at;
        logic [31:0] rdata;
        logic        stray;
        int          stalls;
        logic        gated;
        logic        ealign;
        logic        etmo;
        logic [31:0] load;
    } vec_t;

    vec_t vecs[12];
    vec_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cur_vec = -1;
    int   cur_cyc = 0;

    function automatic vec_t mk(input logic rd, input logic wr, input logic rw,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int ack_at, input logic [31:0] rdata, input logic stray,
                                input int stalls, input logic gated, input logic ealign,
                                input logic etmo, input logic [31:0] load);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rw = rw; v.addr = addr; v.wdata = wdata;
        v.ack_at = ack_at; v.rdata = rdata; v.stray = stray; v.stalls = stalls;
        v.gated = gated; v.ealign = ealign; v.etmo = etmo; v.load = load;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d cyc %0d): got %h, expected %h", name, cur_vec, cur_cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d cyc %0d): got %b, expected %b", name, cur_vec, cur_cyc, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   last;
        last = v.stalls + 1;
        @(posedge clk); #1;
        mem_MemRead  = v.rd;
        mem_MemWrite = v.wr;
        wb_RegWrite  = v.rw;
        AluResult    = v.addr;
        MuxForwardB  = v.wdata;
        sb.push_back(v);
        for (int cyc = 1; cyc <= last; cyc++) begin
            cur_cyc = cyc;
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            mem_ack   = (v.ack_at != 0 && cyc - 1 == v.ack_at) || (v.stray && cyc == last);
            mem_rdata = (v.stray && cyc == last) ? STRAY_DATA : v.rdata;
            @(negedge clk);
            chk1("stall", stall, cyc <= v.stalls);
            chk1("mem_req", mem_req, cyc >= 2 && cyc <= v.stalls);
            chk1("err_timeout", err_timeout, v.etmo && cyc == v.stalls);
            chk1("err_align", err_align, v.ealign && cyc == 1);
            if (cyc >= 2 && cyc <= v.stalls) begin
                chk("mem_addr", mem_addr, v.addr);
                chk("mem_wdata", mem_wdata, v.wdata);
                chk1("mem_we", mem_we, v.wr);
            end
            if (cyc == last) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard_empty (vec %0d): got 0 entries, expected 1", cur_vec);
                end else begin
                    e = sb.pop_front();
                    chk1("wb_RegWrite_gated", wb_RegWrite_gated, e.gated);
                    chk("load_data", load_data, e.load);
                end
            end else begin
                chk1("wb_RegWrite_gated_hold", wb_RegWrite_gated, 1'b0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rd  wr  rw  addr          wdata         ack rdata         stray stl gated ealign etmo load
        vecs[0]  = mk(0, 0, 1, 32'h0000_0100, 32'h0,         0, 32'h0,         0,   0, 1,    0,     0,   32'h0);
        vecs[1]  = mk(0, 0, 0, 32'h0000_0104, 32'h0,         0, 32'h0,         0,   0, 0,    0,     0,   32'h0);
        vecs[2]  = mk(1, 0, 1, 32'h0000_0010, 32'h0,         3, 32'hDEAD_BEEF, 0,   4, 1,    0,     0,   32'hDEAD_BEEF);
        vecs[3]  = mk(0, 1, 0, 32'h0000_0020, 32'h1234_5678, 1, 32'hDEAD_BEEF, 0,   2, 0,    0,     0,   32'hDEAD_BEEF);
        vecs[4]  = mk(1, 0, 1, 32'h0000_0013, 32'h0,         0, 32'h0,         0,   0, 0,    1,     0,   32'hDEAD_BEEF);
        vecs[5]  = mk(0, 1, 0, 32'h0000_0022, 32'h5A5A_5A5A, 0, 32'h0,         0,   0, 0,    1,     0,   32'hDEAD_BEEF);
        vecs[6]  = mk(1, 0, 1, 32'h0000_0040, 32'h0,         0, 32'h0,         1,   5, 0,    0,     1,   32'hDEAD_BEEF);
        vecs[7]  = mk(0, 0, 1, 32'h0000_0044, 32'h0,         0, 32'h0,         0,   0, 1,    0,     0,   32'hDEAD_BEEF);
        vecs[8]  = mk(1, 1, 0, 32'h0000_0030, 32'hA5A5_A5A5, 2, 32'hDEAD_BEEF, 0,   3, 0,    0,     0,   32'hDEAD_BEEF);
        vecs[9]  = mk(1, 0, 1, 32'h0000_0044, 32'h0,         4, 32'h0BAD_CAFE, 0,   5, 1,    0,     0,   32'h0BAD_CAFE);
        vecs[10] = mk(1, 0, 1, 32'hFFFF_FFFC, 32'h0,         1, 32'h5555_AAAA, 0,   2, 1,    0,     0,   32'h5555_AAAA);
        vecs[11] = mk(1, 0, 0, 32'h0000_0008, 32'h0,         2, 32'h0000_0077, 0,   3, 0,    0,     0,   32'h0000_0077);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk1("rst_err_align", err_align, 1'b0);
        chk1("rst_err_timeout", err_timeout, 1'b0);
        chk1("rst_gated", wb_RegWrite_gated, 1'b0);

        for (int i = 0; i < 12; i++) begin
            cur_vec = i;
            run_vec(vecs[i]);
        end

        // Reset while a load is waiting for its ack.
        cur_vec = 100;
        cur_cyc = 0;
        @(posedge clk); #1;
        mem_ack      = 1'b0;
        mem_MemRead  = 1'b1;
        mem_MemWrite = 1'b0;
        wb_RegWrite  = 1'b1;
        AluResult    = 32'h0000_0050;
        @(negedge clk);
        @(negedge clk);
        chk1("midrst_req_before", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("midrst_req", mem_req, 1'b0);
        chk1("midrst_stall_idle_decode", stall, 1'b1);
        chk1("midrst_err_timeout", err_timeout, 1'b0);
        chk1("midrst_err_align", err_align, 1'b0);
        chk("midrst_load_data", load_data, 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        mem_MemRead = 1'b0;
        wb_RegWrite = 1'b0;
        #1;
        chk1("midrst_stall_cleared", stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        cur_vec = 101;
        run_vec(mk(1, 0, 1, 32'h0000_0060, 32'h0, 2, 32'h600D_F00D, 0, 3, 1, 0, 0, 32'h600D_F00D));

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer for the MEM stage of the five-stage pipeline. It takes the memory-control and address/data fields held in the EX/MEM pipeline register, drives a variable-latency data-memory handshake, and freezes the front of the pipeline while an access is outstanding. It also turns misaligned and timed-out accesses into write-back bubbles. It sits between the EX/MEM register outputs and the MEM/WB register inputs.

## Interface
- TIMEOUT, 255: max ACCESS cycles without mem_ack before abort (1..65535)
- CNT_W, $clog2(TIMEOUT+1): timeout counter width (derived)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mem_MemRead  in  1  load in EX/MEM
- mem_MemWrite  in  1  store in EX/MEM (both set = treated as store)
- wb_RegWrite  in  1  RegWrite from EX/MEM
- AluResult  in  32  effective address
- MuxForwardB  in  32  store data
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
- wb_RegWrite_gated  out  1  RegWrite toward MEM/WB, bubbled when not DONE/pass-through
- load_data  out  32  read data toward MEM/WB
- mem_req  out  1  memory request (registered)
- mem_we  out  1  1 = write (registered)
- mem_addr  out  32  word-aligned address (registered)
- mem_wdata  out  32  store data (registered)
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  32  read data, valid with mem_ack
- err_align  out  1  one-cycle pulse, misaligned access dropped
- err_timeout  out  1  one-cycle pulse, access aborted

## Operation
- access = mem_MemRead | mem_MemWrite; aligned = AluResult[1:0]==0.
- States: IDLE, ACCESS, DONE.
- IDLE: access&aligned -> latch mem_addr/mem_wdata/mem_we, go ACCESS; stall=1. access&~aligned -> stay IDLE, stall=0, err_align=1, wb_RegWrite_gated=0, no request. ~access -> stall=0, wb_RegWrite_gated=wb_RegWrite.
- ACCESS: mem_req=1, stall=1, wb_RegWrite_gated=0, counter increments. mem_ack -> capture mem_rdata into load_data, go DONE. Counter reaching TIMEOUT without ack -> err_timeout=1, set fault, go DONE.
- DONE: stall=0, mem_req=0, wb_RegWrite_gated=wb_RegWrite&~fault; pipeline advances at this edge; next state IDLE, fault cleared, counter cleared.
- DONE exists so the held instruction is not re-issued; IDLE always sees the next instruction.
- mem_ack outside ACCESS ignored; mem_addr/we/wdata stable throughout ACCESS.
- load_data holds last captured value; reads of timed-out loads return the stale value with RegWrite bubbled.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, load_data 0, counter 0, fault 0, err_* 0; stall reflects IDLE decode.
- Non-memory instruction: 0 added cycles.
- Memory op with ack on first ACCESS cycle: IDLE(t), ACCESS(t+1), DONE(t+2): 2 stall cycles; each extra ack-wait cycle adds 1.
- Timeout: err_timeout in the ACCESS cycle where the counter equals TIMEOUT; DONE next cycle.
- mem_ack coincident with the timeout cycle: ack wins, no error.
- Reset mid-ACCESS: mem_req drops asynchronously, in-flight access abandoned, no error pulse.
- err_align/err_timeout never both high in one cycle.

## Structure
- Shared pipeline package: state enum (IDLE/ACCESS/DONE), alignment mask constant, default TIMEOUT.
- One sub-module: dmem_timeout_cnt (clear, enable, parameterised width, expired flag).
- FSM, request registers and read-data capture stay in the top.

## Test plan
- ALU instruction, wb_RegWrite=1, no access -> stall=0 every cycle, wb_RegWrite_gated=1, mem_req never asserted.
- Load at 0x0000_0010, ack after 3 ACCESS cycles with rdata 0xDEADBEEF -> stall high 4 cycles, load_data=0xDEADBEEF and wb_RegWrite_gated=1 in DONE.
- Store at 0x0000_0020, data 0x1234_5678, immediate ack -> mem_we=1, addr/wdata stable while mem_req=1, 2 stall cycles, wb_RegWrite_gated=0 in DONE.
- Load at 0x0000_0013 -> err_align pulse, no mem_req, stall=0, wb_RegWrite_gated=0.
- TIMEOUT=4, no ack -> err_timeout on 4th ACCESS cycle, DONE with wb_RegWrite_gated=0; stray ack in DONE ignored.
- rst_n low during ACCESS -> mem_req=0 immediately, state IDLE, next load completes normally.
